// File: rtl/bus_arbiter.sv
// Round-robin arbiter that serialises NREQ requester slots onto one single-port memory.
// Every output is a register; the next-state process computes all of them together.
module bus_arbiter #(
  parameter int NREQ = 4,
  parameter int AW   = 8,
  parameter int DW   = 32
) (
  input  logic               CLK,
  input  logic               RST_N,
  input  logic [NREQ-1:0]    req_rd,
  input  logic [NREQ-1:0]    req_wr,
  input  logic [NREQ*AW-1:0] req_addr,
  input  logic [NREQ*DW-1:0] req_wdata,
  output logic [NREQ-1:0]    ack,
  output logic [DW-1:0]      rdata,
  output logic               mem_rd,
  output logic               mem_wr,
  output logic [AW-1:0]      mem_addr,
  output logic [DW-1:0]      mem_wdata,
  input  logic [DW-1:0]      mem_rdata,
  output logic               busy,
  output logic               err,
  output logic [1:0]         o_dbg_state
);

  localparam int GW = (NREQ > 2) ? 2 : 1;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ISSUE   = 2'd1,
    S_CAPTURE = 2'd2,
    S_RESP    = 2'd3
  } state_t;

  // Handshake: a slot raises req_rd/req_wr and holds it with stable addr/wdata
  // until it sees its one-cycle ack bit; it drops the request the cycle after.
  // Requests are only sampled in IDLE, so later changes never disturb a transfer.

  state_t            r_state;
  logic [GW-1:0]     r_g;
  logic [GW-1:0]     r_ptr;
  logic [NREQ-1:0]   r_ack;
  logic [DW-1:0]     r_rdata;
  logic              r_mem_rd;
  logic              r_mem_wr;
  logic [AW-1:0]     r_mem_addr;
  logic [DW-1:0]     r_mem_wdata;
  logic              r_busy;
  logic              r_err;

  state_t            w_state;
  logic [GW-1:0]     w_g;
  logic [GW-1:0]     w_ptr;
  logic [NREQ-1:0]   w_ack;
  logic [DW-1:0]     w_rdata;
  logic              w_mem_rd;
  logic              w_mem_wr;
  logic [AW-1:0]     w_mem_addr;
  logic [DW-1:0]     w_mem_wdata;
  logic              w_busy;
  logic              w_err;
  logic [NREQ-1:0]   w_pend;
  logic [GW-1:0]     w_sel;
  logic [NREQ-1:0]   w_grant_onehot;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state     <= S_IDLE;
      r_g         <= '0;
      r_ptr       <= GW'(NREQ - 1);
      r_ack       <= '0;
      r_rdata     <= '0;
      r_mem_rd    <= 1'b0;
      r_mem_wr    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_busy      <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_state     <= w_state;
      r_g         <= w_g;
      r_ptr       <= w_ptr;
      r_ack       <= w_ack;
      r_rdata     <= w_rdata;
      r_mem_rd    <= w_mem_rd;
      r_mem_wr    <= w_mem_wr;
      r_mem_addr  <= w_mem_addr;
      r_mem_wdata <= w_mem_wdata;
      r_busy      <= w_busy;
      r_err       <= w_err;
    end
  end

  always_comb begin
    w_state        = r_state;
    w_g            = r_g;
    w_ptr          = r_ptr;
    w_ack          = '0;
    w_rdata        = r_rdata;
    w_mem_rd       = 1'b0;
    w_mem_wr       = 1'b0;
    w_mem_addr     = '0;
    w_mem_wdata    = '0;
    w_err          = r_err;
    w_pend         = req_rd | req_wr;
    w_sel          = r_ptr;
    w_grant_onehot = NREQ'(1) << r_g;

    // Scan from farthest to nearest so the slot closest after ptr wins.
    for (int k = NREQ; k >= 1; k--) begin
      int idx;
      idx = (int'(r_ptr) + k) % NREQ;
      if (w_pend[idx]) w_sel = GW'(idx);
    end

    case (r_state)
      S_IDLE: begin
        if (|w_pend) begin
          w_state     = S_ISSUE;
          w_g         = w_sel;
          w_ptr       = w_sel;
          w_mem_rd    = req_rd[w_sel];
          w_mem_wr    = ~req_rd[w_sel];
          w_mem_addr  = req_addr[int'(w_sel)*AW +: AW];
          w_mem_wdata = req_wdata[int'(w_sel)*DW +: DW];
          if (req_rd[w_sel] && req_wr[w_sel]) w_err = 1'b1;
        end
      end
      S_ISSUE: begin
        // The issued strobe doubles as the latched op: reads need a capture cycle.
        if (r_mem_rd) begin
          w_state = S_CAPTURE;
        end else begin
          w_state = S_RESP;
          w_ack   = w_grant_onehot;
        end
      end
      S_CAPTURE: begin
        w_rdata = mem_rdata;
        w_state = S_RESP;
        w_ack   = w_grant_onehot;
      end
      S_RESP: begin
        w_state = S_IDLE;
      end
      default: begin
        w_state = S_IDLE;
      end
    endcase

    w_busy = (w_state != S_IDLE);
  end

  assign ack         = r_ack;
  assign rdata       = r_rdata;
  assign mem_rd      = r_mem_rd;
  assign mem_wr      = r_mem_wr;
  assign mem_addr    = r_mem_addr;
  assign mem_wdata   = r_mem_wdata;
  assign busy        = r_busy;
  assign err         = r_err;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed bench for bus_arbiter: write, read, fairness, error, async reset and idle cases.
module tb_bus_arbiter;

  localparam int NREQ = 4;
  localparam int AW   = 8;
  localparam int DW   = 32;

  logic               CLK;
  logic               RST_N;
  logic [NREQ-1:0]    req_rd;
  logic [NREQ-1:0]    req_wr;
  logic [NREQ*AW-1:0] req_addr;
  logic [NREQ*DW-1:0] req_wdata;
  logic [NREQ-1:0]    ack;
  logic [DW-1:0]      rdata;
  logic               mem_rd;
  logic               mem_wr;
  logic [AW-1:0]      mem_addr;
  logic [DW-1:0]      mem_wdata;
  logic [DW-1:0]      mem_rdata;
  logic               busy;
  logic               err;
  logic [1:0]         dbg_state;

  logic [DW-1:0] mem_model [0:255];
  int n_cmp;
  int n_err;

  bus_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW)) dut (
    .CLK         (CLK),
    .RST_N       (RST_N),
    .req_rd      (req_rd),
    .req_wr      (req_wr),
    .req_addr    (req_addr),
    .req_wdata   (req_wdata),
    .ack         (ack),
    .rdata       (rdata),
    .mem_rd      (mem_rd),
    .mem_wr      (mem_wr),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_rdata   (mem_rdata),
    .busy        (busy),
    .err         (err),
    .o_dbg_state (dbg_state)
  );

  // clock / reset
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // memory model: read data valid the cycle after mem_rd
  always @(posedge CLK) begin
    if (mem_wr) mem_model[mem_addr] <= mem_wdata;
    if (mem_rd) mem_rdata <= mem_model[mem_addr];
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic set_req(input int s, input bit rd, input bit wr,
                         input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_rd[s]            = rd;
    req_wr[s]            = wr;
    req_addr[s*AW +: AW] = a;
    req_wdata[s*DW +: DW] = d;
  endtask

  task automatic clr_req();
    req_rd    = '0;
    req_wr    = '0;
    req_addr  = '0;
    req_wdata = '0;
  endtask

  // Steps until ack appears (bounded), then checks the ack value and step count.
  task automatic wait_ack(input string tag, input logic [NREQ-1:0] exp_ack, input int exp_cyc);
    int cyc;
    cyc = 0;
    do begin
      step();
      cyc++;
    end while (ack == '0 && cyc < 12);
    check({tag, "_ack"}, ack, exp_ack);
    check({tag, "_lat"}, cyc, exp_cyc);
  endtask

  task automatic do_reset();
    RST_N = 1'b0;
    clr_req();
    repeat (2) step();
    RST_N = 1'b1;
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    mem_rdata = '0;
    for (int i = 0; i < 256; i++) mem_model[i] = '0;
    mem_model[8'h05] = 32'h12345678;
    mem_model[8'h20] = 32'hCAFEF00D;
    mem_model[8'h30] = 32'hA5A5A5A5;
    clr_req();
    do_reset();

    // reset state
    check("rst_outs", {ack, mem_rd, mem_wr, mem_addr, busy, err}, '0);
    check("rst_rdata", rdata, 0);
    check("rst_wdata", mem_wdata, 0);
    check("rst_state", dbg_state, 0);

    // write: slot 0
    set_req(0, 1'b0, 1'b1, 8'h10, 32'hDEADBEEF);
    step();
    check("wr_mem_wr", mem_wr, 1);
    check("wr_mem_rd", mem_rd, 0);
    check("wr_addr", mem_addr, 8'h10);
    check("wr_wdata", mem_wdata, 32'hDEADBEEF);
    check("wr_busy1", busy, 1);
    check("wr_ack_early", ack, 0);
    step();
    check("wr_ack", ack, 4'b0001);
    check("wr_busy2", busy, 1);
    check("wr_strobe_off", {mem_wr, mem_rd}, 0);
    check("wr_addr_clear", mem_addr, 0);
    clr_req();
    step();
    check("wr_idle", {busy, ack}, 0);

    // read: slot 1
    set_req(1, 1'b1, 1'b0, 8'h05, 32'h0);
    step();
    check("rd_mem_rd", mem_rd, 1);
    check("rd_mem_wr", mem_wr, 0);
    check("rd_addr", mem_addr, 8'h05);
    step();
    check("rd_capture", {mem_rd, mem_wr, ack}, 0);
    check("rd_busy_cap", busy, 1);
    step();
    check("rd_ack", ack, 4'b0010);
    check("rd_rdata", rdata, 32'h12345678);
    clr_req();
    step();
    set_req(0, 1'b0, 1'b1, 8'h11, 32'h00000055);
    wait_ack("wr_after_rd", 4'b0001, 2);
    check("rdata_hold", rdata, 32'h12345678);
    clr_req();
    step();

    // fairness: all four slots write continuously
    do_reset();
    for (int s = 0; s < NREQ; s++) set_req(s, 1'b0, 1'b1, AW'(8'h40 + s), DW'(s));
    for (int t = 0; t < 8; t++) begin
      logic [NREQ-1:0] exp_onehot;
      exp_onehot = '0;
      exp_onehot[t % NREQ] = 1'b1;
      wait_ack($sformatf("fair%0d", t), exp_onehot, (t == 0) ? 2 : 3);
    end
    clr_req();
    step();
    check("fair_err", err, 0);

    // error: slot 3 asserts rd and wr together
    set_req(3, 1'b1, 1'b1, 8'h20, 32'h11111111);
    step();
    check("err_mem_rd", mem_rd, 1);
    check("err_mem_wr", mem_wr, 0);
    check("err_addr", mem_addr, 8'h20);
    check("err_set", err, 1);
    step();
    step();
    check("err_ack", ack, 4'b1000);
    check("err_rdata", rdata, 32'hCAFEF00D);
    clr_req();
    step();
    set_req(0, 1'b0, 1'b1, 8'h12, 32'h22222222);
    wait_ack("err_clean", 4'b0001, 2);
    clr_req();
    step();
    check("err_sticky", err, 1);
    do_reset();
    check("err_cleared", err, 0);

    // reset during CAPTURE of a slot 2 read
    set_req(2, 1'b1, 1'b0, 8'h30, 32'h0);
    step();
    check("mid_issue", mem_rd, 1);
    step();
    check("mid_in_capture", dbg_state, 2);
    RST_N = 1'b0;
    clr_req();
    #1;
    check("mid_outs", {ack, mem_rd, mem_wr, mem_addr, busy, err}, '0);
    check("mid_rdata", rdata, 0);
    check("mid_state", dbg_state, 0);
    step();
    check("mid_noack_a", ack, 0);
    RST_N = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      check("mid_noack_b", {ack, busy}, 0);
    end
    set_req(1, 1'b0, 1'b1, 8'h31, 32'h1);
    set_req(2, 1'b0, 1'b1, 8'h32, 32'h2);
    wait_ack("post_rst_first", 4'b0010, 2);
    wait_ack("post_rst_second", 4'b0100, 3);
    clr_req();
    step();

    // idle for 20 cycles
    for (int i = 0; i < 20; i++) begin
      step();
      check("idle", {busy, mem_rd, mem_wr, ack}, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
